// File: rtl/mux_sel_stage.sv
// Registered N:1 operand selector with a single valid/ready hold register, 1-cycle latency.
// Backpressure: in_ready drops while a held entry waits for out_ready; flush empties the stage.
module mux_sel_stage #(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 3,
  parameter int SEL_W    = $clog2(NUM_IN),
  parameter int OOR_HOLD = 1,
  parameter int CNT_W    = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sel_err,
  output logic [CNT_W-1:0]        err_count
);

  logic [WIDTH-1:0] selData;
  logic [WIDTH-1:0] lastGood;
  logic             selInRange;
  logic             accept;
  logic             cntMax;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready && !flush;
  assign selInRange = int'(sel) < NUM_IN;
  assign cntMax     = (err_count == {CNT_W{1'b1}});

  // Decode by comparison so an out-of-range sel never indexes past in_data.
  always_comb begin
    selData = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        selData = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sel_err <= 1'b0;
      err_count   <= '0;
      lastGood    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (selInRange) begin
        out_data    <= selData;
        lastGood    <= selData;
        out_sel_err <= 1'b0;
      end else begin
        out_data    <= (OOR_HOLD != 0) ? lastGood : '0;
        out_sel_err <= 1'b1;
        if (!cntMax) begin
          err_count <= err_count + 1'b1;
        end
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_sel_stage.sv
// Bench for mux_sel_stage: directed scenarios on OOR_HOLD=1 and OOR_HOLD=0 instances,
// then a randomized run against a queue-based transaction model.
module tb_mux_sel_stage;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [N*W-1:0] inData;
  logic [SW-1:0] sel;
  logic          inValid, flush, outReady;

  logic [W-1:0]  dataH, dataZ;
  logic          validH, validZ, errH, errZ, readyH, readyZ;
  logic [CW-1:0] cntH, cntZ;

  int nCmp  = 0;
  int nFail = 0;

  logic [W-1:0] words [3];

  always #5 Clk = ~Clk;

  mux_sel_stage #(.WIDTH(W), .NUM_IN(N), .OOR_HOLD(1), .CNT_W(CW)) dutHold (
    .Clk(Clk), .Reset_n(Reset_n), .in_data(inData), .sel(sel), .in_valid(inValid),
    .in_ready(readyH), .flush(flush), .out_data(dataH), .out_valid(validH),
    .out_ready(outReady), .out_sel_err(errH), .err_count(cntH)
  );

  mux_sel_stage #(.WIDTH(W), .NUM_IN(N), .OOR_HOLD(0), .CNT_W(CW)) dutZero (
    .Clk(Clk), .Reset_n(Reset_n), .in_data(inData), .sel(sel), .in_valid(inValid),
    .in_ready(readyZ), .flush(flush), .out_data(dataZ), .out_valid(validZ),
    .out_ready(outReady), .out_sel_err(errZ), .err_count(cntZ)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic loadWords();
    words[0] = 32'h1111_1111;
    words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333;
    inData   = {words[2], words[1], words[0]};
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; inValid = 1'b0; flush = 1'b0; outReady = 1'b0; sel = '0;
    loadWords();
    step();
    nCmp++;
    if ({validH, errH, dataH, cntH} !== '0) begin
      nFail++;
      $display("FAIL reset_hold: valid=%b err=%b data=%h cnt=%0d, want all zero", validH, errH, dataH, cntH);
    end
    nCmp++;
    if ({validZ, errZ, dataZ, cntZ} !== '0) begin
      nFail++;
      $display("FAIL reset_zero: valid=%b err=%b data=%h cnt=%0d, want all zero", validZ, errZ, dataZ, cntZ);
    end
    nCmp++;
    if (readyH !== 1'b1) begin
      nFail++;
      $display("FAIL reset_ready: in_ready=%b, want 1", readyH);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    sel = 2'd1; inValid = 1'b1; outReady = 1'b1;
    step();
    nCmp++;
    if ({validH, errH, dataH} !== {1'b1, 1'b0, 32'h2222_2222}) begin
      nFail++;
      $display("FAIL single: valid=%b err=%b data=%h, want 1 0 22222222", validH, errH, dataH);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      sel = SW'(k);
      #1;
      nCmp++;
      if (readyH !== 1'b1) begin
        nFail++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b, want 1", k, readyH);
      end
      step();
      nCmp++;
      if ({validH, dataH} !== {1'b1, words[k]}) begin
        nFail++;
        $display("FAIL b2b_data[%0d]: valid=%b data=%h, want 1 %h", k, validH, dataH, words[k]);
      end
    end
    inValid = 1'b0;
    step();
    nCmp++;
    if (validH !== 1'b0) begin
      nFail++;
      $display("FAIL drain: valid=%b, want 0", validH);
    end
  endtask

  task automatic test_stall();
    sel = 2'd0; inValid = 1'b1; outReady = 1'b0;
    step();
    inData = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    sel = 2'd2;
    for (int c = 0; c < 5; c++) begin
      #1;
      nCmp++;
      if (readyH !== 1'b0) begin
        nFail++;
        $display("FAIL stall_ready[%0d]: in_ready=%b, want 0", c, readyH);
      end
      step();
      nCmp++;
      if ({validH, dataH} !== {1'b1, 32'h1111_1111}) begin
        nFail++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h, want 1 11111111", c, validH, dataH);
      end
    end
    outReady = 1'b1;
    #1;
    nCmp++;
    if (readyH !== 1'b1) begin
      nFail++;
      $display("FAIL stall_release_ready: in_ready=%b, want 1", readyH);
    end
    step();
    nCmp++;
    if ({validH, dataH} !== {1'b1, 32'hCCCC_CCCC}) begin
      nFail++;
      $display("FAIL stall_release: valid=%b data=%h, want 1 cccccccc", validH, dataH);
    end
    inValid = 1'b0;
    loadWords();
    step();
  endtask

  task automatic test_oor();
    sel = 2'd2; inValid = 1'b1; outReady = 1'b1;
    step();
    sel = 2'd3;
    step();
    nCmp++;
    if ({validH, errH, dataH, cntH} !== {1'b1, 1'b1, 32'h3333_3333, 8'd1}) begin
      nFail++;
      $display("FAIL oor_hold: valid=%b err=%b data=%h cnt=%0d, want 1 1 33333333 1", validH, errH, dataH, cntH);
    end
    nCmp++;
    if ({validZ, errZ, dataZ, cntZ} !== {1'b1, 1'b1, 32'h0, 8'd1}) begin
      nFail++;
      $display("FAIL oor_zero: valid=%b err=%b data=%h cnt=%0d, want 1 1 0 1", validZ, errZ, dataZ, cntZ);
    end
    inValid = 1'b0;
    step();
    nCmp++;
    if ({validH, errH, dataH} !== {1'b0, 1'b1, 32'h3333_3333}) begin
      nFail++;
      $display("FAIL oor_drain_hold: valid=%b err=%b data=%h, want 0 1 33333333", validH, errH, dataH);
    end
    sel = 2'd0; inValid = 1'b1;
    step();
    nCmp++;
    if ({errH, dataH, cntH} !== {1'b0, 32'h1111_1111, 8'd1}) begin
      nFail++;
      $display("FAIL oor_recover: err=%b data=%h cnt=%0d, want 0 11111111 1", errH, dataH, cntH);
    end
    inValid = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    int expCnt;
    expCnt = 1;
    sel = 2'd3; inValid = 1'b1; outReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (expCnt < 255) expCnt++;
      nCmp++;
      if (cntH !== CW'(expCnt)) begin
        nFail++;
        $display("FAIL saturate[%0d]: err_count=%0d, want %0d", i, cntH, expCnt);
      end
    end
    nCmp++;
    if ({cntH, cntZ} !== {8'd255, 8'd255}) begin
      nFail++;
      $display("FAIL saturate_final: hold=%0d zero=%0d, want 255 255", cntH, cntZ);
    end
    inValid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    sel = 2'd0; inValid = 1'b1; outReady = 1'b1;
    step();
    flush = 1'b1; sel = 2'd2; outReady = 1'b0;
    step();
    nCmp++;
    if ({validH, dataH, cntH} !== {1'b0, 32'h1111_1111, 8'd255}) begin
      nFail++;
      $display("FAIL flush_full: valid=%b data=%h cnt=%0d, want 0 11111111 255", validH, dataH, cntH);
    end
    outReady = 1'b1;
    #1;
    nCmp++;
    if (readyH !== 1'b1) begin
      nFail++;
      $display("FAIL flush_ready: in_ready=%b, want 1", readyH);
    end
    step();
    nCmp++;
    if (validH !== 1'b0) begin
      nFail++;
      $display("FAIL flush_empty: valid=%b, want 0", validH);
    end
    flush = 1'b0; sel = 2'd3;
    step();
    nCmp++;
    if ({validH, errH, dataH} !== {1'b1, 1'b1, 32'h1111_1111}) begin
      nFail++;
      $display("FAIL flush_lastgood: valid=%b err=%b data=%h, want 1 1 11111111", validH, errH, dataH);
    end
    inValid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    sel = 2'd1; inValid = 1'b1; outReady = 1'b0;
    step();
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    nCmp++;
    if ({validH, errH, dataH, cntH} !== '0) begin
      nFail++;
      $display("FAIL reset_mid_hold: valid=%b err=%b data=%h cnt=%0d, want all zero", validH, errH, dataH, cntH);
    end
    nCmp++;
    if ({validZ, errZ, dataZ, cntZ} !== '0) begin
      nFail++;
      $display("FAIL reset_mid_zero: valid=%b err=%b data=%h cnt=%0d, want all zero", validZ, errZ, dataZ, cntZ);
    end
    inValid = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [W-1:0] dHold;
    logic [W-1:0] dZero;
    logic         err;
  } entry_t;

  task automatic test_random();
    entry_t       expQ[$];
    entry_t       e;
    int           mCnt;
    logic [W-1:0] mLast;
    logic         expReady, acc;
    mCnt  = 0;
    mLast = '0;
    for (int i = 0; i < 500; i++) begin
      inValid  = ($urandom_range(0, 3) != 0);
      sel      = SW'($urandom_range(0, 3));
      outReady = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      inData   = {$urandom, $urandom, $urandom};
      #1;
      expReady = (expQ.size() == 0) || outReady;
      nCmp++;
      if ({readyH, readyZ} !== {expReady, expReady}) begin
        nFail++;
        $display("FAIL rand_ready[%0d]: hold=%b zero=%b, want %b", i, readyH, readyZ, expReady);
      end
      acc = inValid && expReady && !flush;
      if (flush) begin
        expQ.delete();
      end else begin
        if (expQ.size() != 0 && outReady) expQ.delete();
        if (acc) begin
          if (int'(sel) < N) begin
            e.dHold = inData[int'(sel)*W +: W];
            e.dZero = e.dHold;
            e.err   = 1'b0;
            mLast   = e.dHold;
          end else begin
            e.dHold = mLast;
            e.dZero = '0;
            e.err   = 1'b1;
            if (mCnt < 255) mCnt++;
          end
          expQ.push_back(e);
        end
      end
      step();
      nCmp++;
      if ({validH, validZ, cntH, cntZ} !== {expQ.size() != 0, expQ.size() != 0, CW'(mCnt), CW'(mCnt)}) begin
        nFail++;
        $display("FAIL rand_state[%0d]: valid=%b/%b cnt=%0d/%0d, want %b cnt %0d",
                 i, validH, validZ, cntH, cntZ, expQ.size() != 0, mCnt);
      end
      if (expQ.size() != 0) begin
        nCmp++;
        if ({dataH, dataZ, errH, errZ} !== {expQ[0].dHold, expQ[0].dZero, expQ[0].err, expQ[0].err}) begin
          nFail++;
          $display("FAIL rand_data[%0d]: data=%h/%h err=%b/%b, want %h/%h err %b",
                   i, dataH, dataZ, errH, errZ, expQ[0].dHold, expQ[0].dZero, expQ[0].err);
        end
      end
    end
    inValid = 1'b0; flush = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_oor();
    test_saturate();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
